// File: rtl/ar_read_scheduler_if.sv
// rtl/ar_read_scheduler_if.sv - AR request, slave AR handshake and master R status bundle for the read scheduler
interface ar_read_scheduler_if;
  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_SIZE_BITS = 3;

  // Master-side AR channels
  logic [AXI_ID_BITS-1:0]   ARID_M0,    ARID_M1;
  logic [AXI_ADDR_BITS-1:0] ARADDR_M0,  ARADDR_M1;
  logic [AXI_LEN_BITS-1:0]  ARLEN_M0,   ARLEN_M1;
  logic [AXI_SIZE_BITS-1:0] ARSIZE_M0,  ARSIZE_M1;
  logic [1:0]               ARBURST_M0, ARBURST_M1;
  logic                     ARVALID_M0, ARVALID_M1;
  logic                     ARREADY_M0, ARREADY_M1;

  // Shared slave-side AR payload
  logic [AXI_IDS_BITS-1:0]  ARID_S;
  logic [AXI_ADDR_BITS-1:0] ARADDR_S;
  logic [AXI_LEN_BITS-1:0]  ARLEN_S;
  logic [AXI_SIZE_BITS-1:0] ARSIZE_S;
  logic [1:0]               ARBURST_S;

  // Per-slave AR handshake
  logic ARVALID_S0, ARVALID_S1, ARVALID_S2, ARVALID_S4, ARVALID_DEFAULT;
  logic ARREADY_S0, ARREADY_S1, ARREADY_S2, ARREADY_S4, ARREADY_DEFAULT;

  // Master-side R channel observation
  logic RVALID_M0, RVALID_M1;
  logic RREADY_M0, RREADY_M1;
  logic RLAST_M0,  RLAST_M1;

  // Selection published to the R mux
  logic [4:0] SLAVE_SEL;
  logic       MASTER_SEL;
  logic       BUSY;
  logic       LEN_ERR;

  // Environment view: masters, slaves and R mux around the scheduler
  modport master (
    output ARID_M0, ARID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
           ARSIZE_M0, ARSIZE_M1, ARBURST_M0, ARBURST_M1, ARVALID_M0, ARVALID_M1,
           ARREADY_S0, ARREADY_S1, ARREADY_S2, ARREADY_S4, ARREADY_DEFAULT,
           RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1, RLAST_M0, RLAST_M1,
    input  ARREADY_M0, ARREADY_M1, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
           ARVALID_S0, ARVALID_S1, ARVALID_S2, ARVALID_S4, ARVALID_DEFAULT,
           SLAVE_SEL, MASTER_SEL, BUSY, LEN_ERR
  );

  // Scheduler view
  modport slave (
    input  ARID_M0, ARID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
           ARSIZE_M0, ARSIZE_M1, ARBURST_M0, ARBURST_M1, ARVALID_M0, ARVALID_M1,
           ARREADY_S0, ARREADY_S1, ARREADY_S2, ARREADY_S4, ARREADY_DEFAULT,
           RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1, RLAST_M0, RLAST_M1,
    output ARREADY_M0, ARREADY_M1, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
           ARVALID_S0, ARVALID_S1, ARVALID_S2, ARVALID_S4, ARVALID_DEFAULT,
           SLAVE_SEL, MASTER_SEL, BUSY, LEN_ERR
  );
endinterface

// File: rtl/ar_read_scheduler.sv
// rtl/ar_read_scheduler.sv - round-robin AR arbiter with address decode and single-outstanding read sequencing
module ar_read_scheduler (
  input  logic               ACLK,
  input  logic               ARESET,
  ar_read_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        rr_q, rr_d;          // 1 = M1 wins a tie
  logic        owner_q, owner_d;    // 0 = M0
  logic [4:0]  slave_q, slave_d;    // {DEFAULT,S4,S2,S1,S0}
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [3:0]  cnt_q, cnt_d;        // non-last beats seen so far
  logic        len_err_q, len_err_d;

  logic        gnt_m0, gnt_m1, grant_en;
  logic [31:0] req_addr;
  logic        sel_ready;
  logic        beat, beat_last;

  // Address map: S0 16 KiB at 0, S1/S2 64 KiB windows, S4 2 MiB at 0x2000_0000
  function automatic logic [4:0] decode(input logic [31:0] a);
    logic [4:0] sel;
    if (a[31:14] == 18'h0)
      sel = 5'b00001;
    else if (a[31:16] == 16'h0001)
      sel = 5'b00010;
    else if (a[31:16] == 16'h0002)
      sel = 5'b00100;
    else if (a[31:21] == 11'h100)
      sel = 5'b01000;
    else
      sel = 5'b10000;
    return sel;
  endfunction

  // Tie goes to the master named by rr_q; a lone requester always wins
  always_comb begin
    gnt_m1   = bus.ARVALID_M1 & (~bus.ARVALID_M0 | rr_q);
    gnt_m0   = bus.ARVALID_M0 & ~gnt_m1;
    grant_en = (state_q == IDLE) & ~ARESET;
    req_addr = gnt_m1 ? bus.ARADDR_M1 : bus.ARADDR_M0;
  end

  // Selected-slave ready and owner R beat qualification
  always_comb begin
    sel_ready = |(slave_q & {bus.ARREADY_DEFAULT, bus.ARREADY_S4, bus.ARREADY_S2,
                             bus.ARREADY_S1, bus.ARREADY_S0});
    if (owner_q) begin
      beat      = bus.RVALID_M1 & bus.RREADY_M1;
      beat_last = bus.RLAST_M1;
    end else begin
      beat      = bus.RVALID_M0 & bus.RREADY_M0;
      beat_last = bus.RLAST_M0;
    end
  end

  // Next-state for the FSM and all latched request fields
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    slave_d   = slave_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    len_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_m0 | gnt_m1) begin
          owner_d = gnt_m1;
          rr_d    = gnt_m0;
          slave_d = decode(req_addr);
          id_d    = gnt_m1 ? bus.ARID_M1    : bus.ARID_M0;
          addr_d  = req_addr;
          len_d   = gnt_m1 ? bus.ARLEN_M1   : bus.ARLEN_M0;
          size_d  = gnt_m1 ? bus.ARSIZE_M1  : bus.ARSIZE_M0;
          burst_d = gnt_m1 ? bus.ARBURST_M1 : bus.ARBURST_M0;
          cnt_d   = 4'd0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (sel_ready)
          state_d = DATA;
      end
      DATA: begin
        if (beat) begin
          if (beat_last) begin
            len_err_d = (cnt_q != len_q);
            state_d   = IDLE;
          end else begin
            len_err_d = (cnt_q == len_q);
            if (cnt_q != 4'hF)
              cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any transaction without a length error
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      owner_q   <= 1'b0;
      slave_q   <= 5'b0;
      id_q      <= 4'b0;
      addr_q    <= 32'b0;
      len_q     <= 4'b0;
      size_q    <= 3'b0;
      burst_q   <= 2'b0;
      cnt_q     <= 4'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      slave_q   <= slave_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign bus.ARREADY_M0 = grant_en & gnt_m0;
  assign bus.ARREADY_M1 = grant_en & gnt_m1;

  assign bus.ARID_S    = {3'b000, owner_q, id_q};
  assign bus.ARADDR_S  = addr_q;
  assign bus.ARLEN_S   = len_q;
  assign bus.ARSIZE_S  = size_q;
  assign bus.ARBURST_S = burst_q;

  assign bus.ARVALID_S0      = (state_q == ADDR) & slave_q[0];
  assign bus.ARVALID_S1      = (state_q == ADDR) & slave_q[1];
  assign bus.ARVALID_S2      = (state_q == ADDR) & slave_q[2];
  assign bus.ARVALID_S4      = (state_q == ADDR) & slave_q[3];
  assign bus.ARVALID_DEFAULT = (state_q == ADDR) & slave_q[4];

  assign bus.BUSY       = (state_q != IDLE);
  assign bus.SLAVE_SEL  = (state_q != IDLE) ? slave_q : 5'b0;
  assign bus.MASTER_SEL = owner_q;
  assign bus.LEN_ERR    = len_err_q;

endmodule

// File: tb/tb_ar_read_scheduler.sv
// tb/tb_ar_read_scheduler.sv - table-driven scoreboard bench for ar_read_scheduler
module tb_ar_read_scheduler;

  logic ACLK = 1'b0;
  logic ARESET;

  always #5 ACLK = ~ACLK;

  ar_read_scheduler_if bus ();

  ar_read_scheduler dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  localparam logic [3:0] ID_M0    = 4'h3;
  localparam logic [3:0] ID_M1    = 4'hA;
  localparam logic [2:0] SIZE_M0  = 3'd2;
  localparam logic [2:0] SIZE_M1  = 3'd3;
  localparam logic [1:0] BURST_M0 = 2'b01;
  localparam logic [1:0] BURST_M1 = 2'b10;

  typedef struct {
    logic [1:0]  req;       // {M1,M0} ARVALID
    logic [31:0] addr;
    logic [3:0]  len;
    int          nbeats;
    logic        exp_m;
    logic [4:0]  exp_slave;
  } vec_t;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [4:0]  slave;
    logic        m;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] s_valid();
    return {bus.ARVALID_DEFAULT, bus.ARVALID_S4, bus.ARVALID_S2, bus.ARVALID_S1, bus.ARVALID_S0};
  endfunction

  function automatic logic [63:0] all_outputs();
    return {bus.ARREADY_M1, bus.ARREADY_M0, s_valid(), bus.ARID_S, bus.ARADDR_S,
            bus.ARLEN_S, bus.ARSIZE_S, bus.ARBURST_S, bus.SLAVE_SEL, bus.MASTER_SEL,
            bus.BUSY, bus.LEN_ERR};
  endfunction

  task automatic set_sready(input logic [4:0] r);
    bus.ARREADY_S0      = r[0];
    bus.ARREADY_S1      = r[1];
    bus.ARREADY_S2      = r[2];
    bus.ARREADY_S4      = r[3];
    bus.ARREADY_DEFAULT = r[4];
  endtask

  // Owner gets a beat (valid+ready, last); the other master gets optional noise
  task automatic set_r(input logic m, input logic own_v, input logic own_last, input logic oth_v);
    if (m) begin
      bus.RVALID_M1 = own_v; bus.RREADY_M1 = own_v; bus.RLAST_M1 = own_last;
      bus.RVALID_M0 = oth_v; bus.RREADY_M0 = oth_v; bus.RLAST_M0 = oth_v;
    end else begin
      bus.RVALID_M0 = own_v; bus.RREADY_M0 = own_v; bus.RLAST_M0 = own_last;
      bus.RVALID_M1 = oth_v; bus.RREADY_M1 = oth_v; bus.RLAST_M1 = oth_v;
    end
  endtask

  task automatic clear_inputs();
    bus.ARID_M0 = ID_M0;       bus.ARID_M1 = ID_M1;
    bus.ARSIZE_M0 = SIZE_M0;   bus.ARSIZE_M1 = SIZE_M1;
    bus.ARBURST_M0 = BURST_M0; bus.ARBURST_M1 = BURST_M1;
    bus.ARADDR_M0 = '0;        bus.ARADDR_M1 = '0;
    bus.ARLEN_M0 = '0;         bus.ARLEN_M1 = '0;
    bus.ARVALID_M0 = 1'b0;     bus.ARVALID_M1 = 1'b0;
    set_sready(5'b0);
    set_r(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    exp_t e;
    exp_t g;
    int   cnt;
    logic last;
    logic exp_err;
    // IDLE: request, grant in the same cycle
    @(negedge ACLK);
    bus.ARADDR_M0 = v.addr; bus.ARADDR_M1 = v.addr;
    bus.ARLEN_M0  = v.len;  bus.ARLEN_M1  = v.len;
    bus.ARVALID_M0 = v.req[0];
    bus.ARVALID_M1 = v.req[1];
    e.m     = v.exp_m;
    e.id    = {3'b000, v.exp_m, (v.exp_m ? ID_M1 : ID_M0)};
    e.addr  = v.addr;
    e.len   = v.len;
    e.size  = v.exp_m ? SIZE_M1 : SIZE_M0;
    e.burst = v.exp_m ? BURST_M1 : BURST_M0;
    e.slave = v.exp_slave;
    sb.push_back(e);
    #1;
    check({tag, " arready_grant"}, 64'({bus.ARREADY_M1, bus.ARREADY_M0}), 64'(v.exp_m ? 2'b10 : 2'b01));
    check({tag, " idle_busy_sel"}, 64'({bus.BUSY, bus.SLAVE_SEL}), 64'(0));
    // ADDR, first cycle: only non-selected slaves ready, stray owner R beat
    @(negedge ACLK);
    if (v.exp_m) bus.ARVALID_M1 = 1'b0; else bus.ARVALID_M0 = 1'b0;
    set_sready(~v.exp_slave);
    set_r(v.exp_m, 1'b1, 1'b1, 1'b0);
    #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 64'(1), 64'(0));
    end else begin
      g = sb.pop_front();
      check({tag, " arvalid_s"},  64'(s_valid()),       64'(g.slave));
      check({tag, " arid_s"},     64'(bus.ARID_S),      64'(g.id));
      check({tag, " araddr_s"},   64'(bus.ARADDR_S),    64'(g.addr));
      check({tag, " arlen_size_burst"}, 64'({bus.ARLEN_S, bus.ARSIZE_S, bus.ARBURST_S}),
            64'({g.len, g.size, g.burst}));
      check({tag, " sel_busy"},   64'({bus.SLAVE_SEL, bus.MASTER_SEL, bus.BUSY}),
            64'({g.slave, g.m, 1'b1}));
    end
    check({tag, " arready_stall"}, 64'({bus.ARREADY_M1, bus.ARREADY_M0}), 64'(0));
    // ADDR, second cycle: still waiting; now the selected slave accepts
    @(negedge ACLK);
    set_r(v.exp_m, 1'b0, 1'b0, 1'b0);
    set_sready(v.exp_slave);
    #1;
    check({tag, " addr_hold"}, 64'(s_valid()), 64'(v.exp_slave));
    // DATA
    @(negedge ACLK);
    set_sready(5'b0);
    #1;
    check({tag, " data_entry"}, 64'({s_valid(), bus.BUSY, bus.SLAVE_SEL}), 64'({5'b0, 1'b1, v.exp_slave}));
    cnt = 0;
    for (int b = 0; b < v.nbeats; b++) begin
      last    = (b == v.nbeats - 1);
      exp_err = last ? (cnt != int'(v.len)) : (cnt == int'(v.len));
      if (!last && cnt < 15) cnt++;
      set_r(v.exp_m, 1'b1, last, 1'b1);
      if (last) begin
        bus.ARVALID_M0 = 1'b0;
        bus.ARVALID_M1 = 1'b0;
      end
      @(negedge ACLK);
      set_r(v.exp_m, 1'b0, 1'b0, 1'b0);
      #1;
      check($sformatf("%s len_err_beat%0d", tag, b), 64'(bus.LEN_ERR), 64'(exp_err));
      check($sformatf("%s busy_beat%0d", tag, b), 64'(bus.BUSY), 64'(!last));
    end
    check({tag, " idle_sel"}, 64'({bus.SLAVE_SEL, bus.MASTER_SEL}), 64'({5'b0, v.exp_m}));
    @(negedge ACLK);
    #1;
    check({tag, " len_err_clear"}, 64'(bus.LEN_ERR), 64'(0));
  endtask

  initial begin
    vecs[0] = '{2'b11, 32'h0001_0004, 4'd3,  4,  1'b0, 5'b00010};
    vecs[1] = '{2'b11, 32'h0000_3FFC, 4'd0,  1,  1'b1, 5'b00001};
    vecs[2] = '{2'b11, 32'h0002_0000, 4'd1,  2,  1'b0, 5'b00100};
    vecs[3] = '{2'b11, 32'h201F_FFFF, 4'd0,  1,  1'b1, 5'b01000};
    vecs[4] = '{2'b10, 32'h3000_0000, 4'd2,  3,  1'b1, 5'b10000};
    vecs[5] = '{2'b01, 32'h0000_4000, 4'd0,  1,  1'b0, 5'b10000};
    vecs[6] = '{2'b10, 32'h0001_FFFF, 4'd1,  1,  1'b1, 5'b00010};
    vecs[7] = '{2'b01, 32'h2020_0000, 4'd0,  2,  1'b0, 5'b10000};
    vecs[8] = '{2'b11, 32'h0001_0000, 4'd2,  3,  1'b1, 5'b00010};
    vecs[9] = '{2'b01, 32'h0000_0000, 4'd15, 17, 1'b0, 5'b00001};

    clear_inputs();
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    #1;
    check("reset_outputs", all_outputs(), 64'(0));
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    check("post_reset_outputs", all_outputs(), 64'(0));

    for (int i = 0; i < 10; i++)
      do_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset during DATA: abort without LEN_ERR, round-robin pointer back to M0
    @(negedge ACLK);
    bus.ARADDR_M0  = 32'h0001_0000;
    bus.ARLEN_M0   = 4'd3;
    bus.ARVALID_M0 = 1'b1;
    #1;
    check("rst_seq grant", 64'(bus.ARREADY_M0), 64'(1));
    @(negedge ACLK);
    bus.ARVALID_M0 = 1'b0;
    set_sready(5'b00010);
    @(negedge ACLK);
    set_sready(5'b0);
    set_r(1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    check("rst_seq in_data", 64'(bus.BUSY), 64'(1));
    @(negedge ACLK);
    set_r(1'b0, 1'b1, 1'b1, 1'b0);
    ARESET = 1'b1;
    @(negedge ACLK);
    set_r(1'b0, 1'b0, 1'b0, 1'b0);
    ARESET = 1'b0;
    #1;
    check("rst_seq all_zero", all_outputs(), 64'(0));
    do_txn('{2'b11, 32'h0000_0100, 4'd0, 1, 1'b0, 5'b00001}, "after_rst_m0");
    do_txn('{2'b10, 32'h0002_0040, 4'd1, 2, 1'b1, 5'b00100}, "after_rst_m1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
